decode_sequencer: RTL and testbench
===================================

DECODE_SEQUENCER -- requirements
Module: decode_sequencer

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 rom_addr  out  10  microcode ROM address; ROM is synchronous with 1-cycle read latency.
REQ-004 rom_data  in  44  microword read from ROM; bit fields per decode package (DECODE_NEXT_SEL [29:28], DECODE_NEXT [39:30], RST_OUT [42]).
REQ-005 ir_opcode  in  7  opcode field of current instruction register.
REQ-006 alu_zero  in  1  ALU zero flag for conditional microbranch.
REQ-007 irq  in  1  level interrupt request.
REQ-008 irq_enable  in  1  interrupt enable (privilege/flag logic).
REQ-009 stall  in  1  memory/IO wait; freezes sequencing.
REQ-010 uword  out  44  microword driven to control decode; all-zero means NOP.
REQ-011 irq_ack  out  1  one-cycle pulse when interrupt vector taken.
REQ-012 upc  out  10  address of microword currently executing (debug).

Function
REQ-013 States SHALL be PRIME and RUN; register upc holds address whose data is on rom_data.
REQ-014 In PRIME: rom_addr = upc, uword = 0, irq_ack = 0; next state RUN, upc unchanged.
REQ-015 In RUN with stall=0: uword = rom_data; rom_addr = next address; upc <= next address.
REQ-016 In RUN with stall=1: uword = 0, rom_addr = upc, upc unchanged, irq_ack = 0, no interrupt or branch decision taken.
REQ-017 Next address by DECODE_NEXT_SEL: 0 -> DECODE_NEXT; 1 -> dispatch {1'b1, ir_opcode, 2'b00}; 2 -> FETCH_VEC; 3 -> DECODE_NEXT if alu_zero=1 else upc+1.
REQ-018 upc+1 SHALL wrap 10'h3FF -> 10'h000.
REQ-019 If sel=2 and irq=1 and irq_enable=1: next = IRQ_VEC, irq_ack = 1 for that cycle.
REQ-020 If rom_data RST_OUT=1 (RUN, stall=0): next = RESET_VEC, overriding sel and irq; irq_ack = 0.
REQ-021 Priority: stall > RST_OUT > irq > sel decode.
REQ-022 Constants: FETCH_VEC 10'h000, RESET_VEC 10'h004, IRQ_VEC 10'h008; dispatch range 10'h200-10'h3FC.
REQ-023 irq sampled only at sel=2 boundaries; irq deasserting mid-stall SHALL not produce irq_ack.
REQ-024 Every microword executes exactly one RUN non-stalled cycle; no word skipped or repeated except via stall hold.

Reset
REQ-025 While rst=1: state = PRIME, upc = RESET_VEC, rom_addr = RESET_VEC, uword = 0, irq_ack = 0.
REQ-026 Reset assertion mid-stall or mid-branch SHALL abandon the operation immediately (asynchronous).
REQ-027 First executed microword after reset release SHALL be at RESET_VEC, after one PRIME cycle.

Structure
REQ-028 Shared package scp_decode_pkg SHALL hold microword field positions, sel encodings, FETCH_VEC/RESET_VEC/IRQ_VEC, widths 44/10/7.
REQ-029 One combinational sub-module decode_next_mux SHALL compute next address and irq_take from rom_data, upc, ir_opcode, alu_zero, irq, irq_enable.
REQ-030 Sequencer holds only state, upc registers; uword is combinational from rom_data.

Verification
REQ-031 Release rst -> 1 cycle uword=0 with rom_addr=0x004, then uword=ROM[0x004], upc=0x004.
REQ-032 Word at 0x000 with sel=1, ir_opcode=7'h05 -> rom_addr=0x214, next upc=0x214.
REQ-033 sel=3, DECODE_NEXT=0x050 at upc=0x120: alu_zero=1 -> 0x050; alu_zero=0 -> 0x121; at upc=0x3FF, alu_zero=0 -> 0x000.
REQ-034 sel=2, irq=1, irq_enable=1 -> next 0x008, irq_ack high exactly 1 cycle; irq_enable=0 -> next 0x000, irq_ack=0.
REQ-035 stall held 3 cycles during word at 0x030 -> uword=0, rom_addr=0x030, upc=0x030 throughout; word executes once on release.
REQ-036 RST_OUT=1 with sel=2 and irq pending -> next 0x004, irq_ack=0; rst asserted mid-stall -> upc=0x004, PRIME.

Source files
------------

// File: rtl/scp_decode_pkg.sv
// Shared microcode sequencer definitions: widths, microword fields, next-address
// select encodings, fixed vectors and sequencer states.
package scp_decode_pkg;

  localparam int UWORD_W  = 44;
  localparam int UADDR_W  = 10;
  localparam int OPCODE_W = 7;

  // Microword field positions
  localparam int DECODE_NEXT_SEL_LSB = 28;
  localparam int DECODE_NEXT_SEL_MSB = 29;
  localparam int DECODE_NEXT_LSB     = 30;
  localparam int DECODE_NEXT_MSB     = 39;
  localparam int RST_OUT_BIT         = 42;

  localparam logic [UADDR_W-1:0] FETCH_VEC = 10'h000;
  localparam logic [UADDR_W-1:0] RESET_VEC = 10'h004;
  localparam logic [UADDR_W-1:0] IRQ_VEC   = 10'h008;

  typedef enum logic [1:0] {
    SEL_NEXT     = 2'd0,
    SEL_DISPATCH = 2'd1,
    SEL_FETCH    = 2'd2,
    SEL_COND     = 2'd3
  } next_sel_e;

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } seq_state_e;

  // Opcode dispatch lands on a 4-word aligned slot in the upper half of the ROM.
  function automatic logic [UADDR_W-1:0] dispatch_addr(input logic [OPCODE_W-1:0] opcode);
    return {1'b1, opcode, 2'b00};
  endfunction

endpackage

// File: rtl/decode_next_mux.sv
// Combinational next-microaddress selection and interrupt-take decision.
// RST_OUT overrides everything; irq is only considered on fetch boundaries.
module decode_next_mux
  import scp_decode_pkg::*;
(
  input  logic [UWORD_W-1:0]  rom_data,
  input  logic [UADDR_W-1:0]  upc,
  input  logic [OPCODE_W-1:0] ir_opcode,
  input  logic                alu_zero,
  input  logic                irq,
  input  logic                irq_enable,
  output logic [UADDR_W-1:0]  next_addr,
  output logic                irq_take
);

  next_sel_e          sel;
  logic [UADDR_W-1:0] dec_next;
  logic [UADDR_W-1:0] upc_inc;
  logic               rst_out;
  logic               unused_bits;

  assign sel      = next_sel_e'(rom_data[DECODE_NEXT_SEL_MSB:DECODE_NEXT_SEL_LSB]);
  assign dec_next = rom_data[DECODE_NEXT_MSB:DECODE_NEXT_LSB];
  assign rst_out  = rom_data[RST_OUT_BIT];
  assign upc_inc  = upc + 10'd1;

  assign unused_bits = ^{rom_data[UWORD_W-1], rom_data[RST_OUT_BIT-1:DECODE_NEXT_MSB+1],
                         rom_data[DECODE_NEXT_SEL_LSB-1:0]};

  always_comb begin
    next_addr = upc_inc;
    irq_take  = 1'b0;
    unique case (sel)
      SEL_NEXT:     next_addr = dec_next;
      SEL_DISPATCH: next_addr = dispatch_addr(ir_opcode);
      SEL_FETCH: begin
        if (irq && irq_enable) begin
          next_addr = IRQ_VEC;
          irq_take  = 1'b1;
        end else begin
          next_addr = FETCH_VEC;
        end
      end
      SEL_COND:     next_addr = alu_zero ? dec_next : upc_inc;
      default:      next_addr = upc_inc;
    endcase
    // A microcoded reset beats both the select field and a pending interrupt.
    if (rst_out) begin
      next_addr = RESET_VEC;
      irq_take  = 1'b0;
    end
  end

endmodule

// File: rtl/decode_sequencer.sv
// Microcode sequencer: PRIME cycle fills the synchronous ROM pipeline, RUN executes
// one microword per unstalled cycle; stall holds upc and emits NOPs.
module decode_sequencer
  import scp_decode_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  output logic [UADDR_W-1:0]  rom_addr,
  input  logic [UWORD_W-1:0]  rom_data,
  input  logic [OPCODE_W-1:0] ir_opcode,
  input  logic                alu_zero,
  input  logic                irq,
  input  logic                irq_enable,
  input  logic                stall,
  output logic [UWORD_W-1:0]  uword,
  output logic                irq_ack,
  output logic [UADDR_W-1:0]  upc
);

  seq_state_e         state_q, state_d;
  logic [UADDR_W-1:0] upc_q, upc_d;
  logic [UADDR_W-1:0] next_addr;
  logic               irq_take;

  decode_next_mux u_next_mux (
    .rom_data   (rom_data),
    .upc        (upc_q),
    .ir_opcode  (ir_opcode),
    .alu_zero   (alu_zero),
    .irq        (irq),
    .irq_enable (irq_enable),
    .next_addr  (next_addr),
    .irq_take   (irq_take)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_PRIME;
      upc_q   <= RESET_VEC;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
    end
  end

  // rom_addr always points at what rom_data must hold next cycle; holding upc
  // keeps the current word on rom_data across PRIME and stall cycles.
  always_comb begin
    state_d  = state_q;
    upc_d    = upc_q;
    rom_addr = upc_q;
    uword    = '0;
    irq_ack  = 1'b0;
    unique case (state_q)
      ST_PRIME: state_d = ST_RUN;
      ST_RUN: begin
        if (!stall) begin
          uword    = rom_data;
          rom_addr = next_addr;
          upc_d    = next_addr;
          irq_ack  = irq_take;
        end
      end
      default: state_d = ST_PRIME;
    endcase
  end

  assign upc = upc_q;

endmodule

// File: tb/tb_decode_sequencer.sv
// Directed bench for decode_sequencer with a synchronous ROM model.
module tb_decode_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  rom_addr;
  logic [43:0] rom_data;
  logic [6:0]  ir_opcode = 7'h05;
  logic        alu_zero = 1'b0;
  logic        irq = 1'b0;
  logic        irq_enable = 1'b0;
  logic        stall = 1'b0;
  logic [43:0] uword;
  logic        irq_ack;
  logic [9:0]  upc;

  logic [43:0] rom [1024];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  decode_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .ir_opcode  (ir_opcode),
    .alu_zero   (alu_zero),
    .irq        (irq),
    .irq_enable (irq_enable),
    .stall      (stall),
    .uword      (uword),
    .irq_ack    (irq_ack),
    .upc        (upc)
  );

  // Microword: bit43 marker, RST_OUT[42], next[39:30], sel[29:28], address tag[9:0]
  function automatic logic [43:0] mw(input logic [1:0] sel, input logic [9:0] nxt,
                                     input logic rst_out, input logic [9:0] tag);
    logic [43:0] w;
    w        = '0;
    w[43]    = 1'b1;
    w[42]    = rst_out;
    w[39:30] = nxt;
    w[29:28] = sel;
    w[9:0]   = tag;
    return w;
  endfunction

  task automatic check(input string tag, input logic [43:0] obs, input logic [43:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = '0;
    rom[10'h004] = mw(2'd0, 10'h000, 1'b0, 10'h004);
    rom[10'h000] = mw(2'd1, 10'h000, 1'b0, 10'h000);
    rom[10'h214] = mw(2'd0, 10'h120, 1'b0, 10'h214);
    rom[10'h120] = mw(2'd3, 10'h050, 1'b0, 10'h120);
    rom[10'h050] = mw(2'd0, 10'h120, 1'b0, 10'h050);
    rom[10'h121] = mw(2'd0, 10'h3FF, 1'b0, 10'h121);
    rom[10'h3FF] = mw(2'd3, 10'h050, 1'b0, 10'h3FF);
    rom[10'h230] = mw(2'd2, 10'h000, 1'b0, 10'h230);
    rom[10'h008] = mw(2'd2, 10'h000, 1'b0, 10'h008);
    rom[10'h22C] = mw(2'd0, 10'h030, 1'b0, 10'h22C);
    rom[10'h030] = mw(2'd2, 10'h000, 1'b0, 10'h030);
    rom[10'h234] = mw(2'd2, 10'h100, 1'b1, 10'h234);

    tick(); tick();
    #1;
    check("rst_rom_addr", 44'(rom_addr), 44'h004);
    check("rst_upc",      44'(upc),      44'h004);
    check("rst_uword",    uword,         44'h0);
    check("rst_irq_ack",  44'(irq_ack),  44'h0);

    rst = 1'b0; #1;
    check("prime_uword",    uword,         44'h0);
    check("prime_rom_addr", 44'(rom_addr), 44'h004);

    tick(); #1;
    check("first_uword", uword, mw(2'd0, 10'h000, 1'b0, 10'h004));
    check("first_upc",   44'(upc),      44'h004);
    check("first_next",  44'(rom_addr), 44'h000);

    tick(); #1;
    check("dispatch_upc",  44'(upc),      44'h000);
    check("dispatch_addr", 44'(rom_addr), 44'h214);

    tick(); #1;
    check("upc_214",   44'(upc),      44'h214);
    check("next_120",  44'(rom_addr), 44'h120);

    tick(); alu_zero = 1'b1; #1;
    check("cond_taken", 44'(rom_addr), 44'h050);

    tick(); alu_zero = 1'b0; #1;
    check("upc_050", 44'(upc), 44'h050);

    tick(); #1;
    check("cond_upc",      44'(upc),      44'h120);
    check("cond_not_taken", 44'(rom_addr), 44'h121);

    tick(); #1;
    check("next_3ff", 44'(rom_addr), 44'h3FF);

    tick(); ir_opcode = 7'h0C; #1;
    check("upc_3ff",  44'(upc),      44'h3FF);
    check("cond_wrap", 44'(rom_addr), 44'h000);

    tick(); #1;
    check("dispatch_0c", 44'(rom_addr), 44'h230);

    tick(); irq = 1'b1; irq_enable = 1'b1; #1;
    check("irq_next", 44'(rom_addr), 44'h008);
    check("irq_ack",  44'(irq_ack),  44'h1);

    tick(); irq_enable = 1'b0; ir_opcode = 7'h0B; #1;
    check("irq_upc",        44'(upc),      44'h008);
    check("irq_ack_pulse",  44'(irq_ack),  44'h0);
    check("irq_dis_next",   44'(rom_addr), 44'h000);

    tick(); irq = 1'b0; #1;
    check("dispatch_0b", 44'(rom_addr), 44'h22C);

    tick(); #1;
    check("next_030", 44'(rom_addr), 44'h030);

    tick();
    stall = 1'b1; irq = 1'b1; irq_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) irq = 1'b0;
      #1;
      check("stall_uword",    uword,         44'h0);
      check("stall_rom_addr", 44'(rom_addr), 44'h030);
      check("stall_upc",      44'(upc),      44'h030);
      check("stall_irq_ack",  44'(irq_ack),  44'h0);
      tick();
    end
    stall = 1'b0; ir_opcode = 7'h0D; #1;
    check("stall_rel_uword", uword, mw(2'd2, 10'h000, 1'b0, 10'h030));
    check("stall_rel_next",  44'(rom_addr), 44'h000);
    check("stall_rel_ack",   44'(irq_ack),  44'h0);

    tick(); #1;
    check("upc_after_stall", 44'(upc),      44'h000);
    check("dispatch_0d",     44'(rom_addr), 44'h234);

    tick(); irq = 1'b1; irq_enable = 1'b1; #1;
    check("rstout_next", 44'(rom_addr), 44'h004);
    check("rstout_ack",  44'(irq_ack),  44'h0);

    tick(); irq = 1'b0; #1;
    check("rstout_upc", 44'(upc), 44'h004);

    tick(); stall = 1'b1; #1;
    check("pre_rst_upc", 44'(upc), 44'h000);
    #2 rst = 1'b1; #1;
    check("async_rst_upc",      44'(upc),      44'h004);
    check("async_rst_rom_addr", 44'(rom_addr), 44'h004);
    check("async_rst_uword",    uword,         44'h0);

    tick(); rst = 1'b0; stall = 1'b0; #1;
    check("reprime_uword",    uword,         44'h0);
    check("reprime_rom_addr", 44'(rom_addr), 44'h004);
    tick(); #1;
    check("rerun_uword", uword, mw(2'd0, 10'h000, 1'b0, 10'h004));
    check("rerun_upc",   44'(upc), 44'h004);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
